// File: rtl/pre_if_multi_fetch.sv
// ============================================================================
// Module  : pre_if_multi_fetch
// Brief   : Pre-IF PC generation for aligned multi-instruction fetch groups.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pre_if_multi_fetch #(
    parameter int          FETCH_WIDTH   = 2,
    parameter logic [31:0] RESET_PC      = 32'hBFC00000,
    parameter logic [31:0] GENERAL_EX_PC = 32'hBFC00380,
    parameter logic [31:0] REFILL_EX_PC  = 32'hBFC00200
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fs_allowin,
    input  logic                   icache_busy,
    input  logic                   br_taken,
    input  logic                   br_stall,
    input  logic [31:0]            br_target,
    input  logic                   flush,
    input  logic                   flush_refill,
    input  logic                   eret,
    input  logic [31:0]            epc,
    output logic [31:0]            fetch_pc,
    output logic                   req_valid,
    output logic [FETCH_WIDTH-1:0] fetch_mask,
    output logic                   ps_to_fs_valid,
    output logic                   ps_ex,
    output logic [4:0]             ps_excode,
    output logic                   redirect_pending
);

    localparam int          LW          = $clog2(FETCH_WIDTH);
    localparam logic [31:0] GROUP_BYTES = 32'(FETCH_WIDTH * 4);
    localparam logic [31:0] GROUP_MASK  = GROUP_BYTES - 32'd1;
    localparam logic [4:0]  EXCODE_ADEL = 5'h04;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] pending_pc_q, pending_pc_d;
    logic        drop_q, drop_d;

    logic        w_adv;
    logic        w_adv_pc;
    logic        w_run;
    logic        w_exc;
    logic        w_br;
    logic [31:0] w_exc_target;
    logic [31:0] w_seq_pc;
    logic [1:0]  w_slot;

    assign w_adv        = ~icache_busy & fs_allowin;
    // A dropped cycle only squashes the stale response; the PC must not move.
    assign w_adv_pc     = w_adv & ~drop_q;
    assign w_run        = (state_q == ST_RUN);
    assign w_exc        = eret | flush;
    assign w_br         = br_taken & ~br_stall;
    assign w_exc_target = eret ? epc : (flush_refill ? REFILL_EX_PC : GENERAL_EX_PC);
    assign w_seq_pc     = (fetch_pc_q & ~GROUP_MASK) + GROUP_BYTES;

    generate
        if (LW == 0) begin : g_single_slot
            assign w_slot = 2'd0;
        end else begin : g_multi_slot
            assign w_slot = 2'(fetch_pc_q[LW+1:2]);
        end
    endgenerate

    assign ps_ex = (fetch_pc_q[1:0] != 2'b00);

    generate
        for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_mask
            assign fetch_mask[i] = ~ps_ex & (2'(i) >= w_slot);
        end
    endgenerate

    assign fetch_pc         = fetch_pc_q;
    assign ps_excode        = ps_ex ? EXCODE_ADEL : 5'h00;
    assign req_valid        = ~icache_busy & ~ps_ex & ~drop_q & w_run;
    assign ps_to_fs_valid   = w_adv & ~drop_q & w_run;
    assign redirect_pending = (state_q == ST_HOLD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_RUN;
            fetch_pc_q   <= RESET_PC;
            pending_pc_q <= 32'h0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            pending_pc_q <= pending_pc_d;
            drop_q       <= drop_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        pending_pc_d = pending_pc_q;
        drop_d       = drop_q & icache_busy;

        if (w_exc) begin
            // Exception-class redirects win over everything and never wait.
            fetch_pc_d = w_exc_target;
            state_d    = ST_RUN;
            drop_d     = icache_busy;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (w_br) begin
                        if (w_adv_pc) begin
                            fetch_pc_d = br_target;
                        end else begin
                            pending_pc_d = br_target;
                            state_d      = ST_HOLD;
                        end
                    end else if (w_adv_pc) begin
                        fetch_pc_d = w_seq_pc;
                    end
                end
                ST_HOLD: begin
                    // The newest branch replaces the latched one.
                    if (w_br) begin
                        pending_pc_d = br_target;
                        if (!icache_busy) begin
                            fetch_pc_d = br_target;
                            state_d    = ST_RUN;
                        end
                    end else if (!icache_busy) begin
                        fetch_pc_d = pending_pc_q;
                        state_d    = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pre_if_multi_fetch.sv
// ============================================================================
// Module  : tb_pre_if_multi_fetch
// Brief   : Self-checking bench for pre_if_multi_fetch at widths 2 and 4.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pre_if_multi_fetch;

    localparam logic [31:0] RESET_PC      = 32'hBFC00000;
    localparam logic [31:0] GENERAL_EX_PC = 32'hBFC00380;
    localparam logic [31:0] REFILL_EX_PC  = 32'hBFC00200;

    logic        clk = 1'b0;
    logic        reset;
    logic        fs_allowin, icache_busy, br_taken, br_stall, flush, flush_refill, eret;
    logic [31:0] br_target, epc;

    logic [31:0] o2_pc, o4_pc;
    logic        o2_req, o4_req, o2_fsv, o4_fsv, o2_ex, o4_ex, o2_pend, o4_pend;
    logic [1:0]  o2_mask;
    logic [3:0]  o4_mask;
    logic [4:0]  o2_code, o4_code;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pre_if_multi_fetch #(.FETCH_WIDTH(2)) u_dut2 (
        .clk(clk), .reset(reset), .fs_allowin(fs_allowin), .icache_busy(icache_busy),
        .br_taken(br_taken), .br_stall(br_stall), .br_target(br_target),
        .flush(flush), .flush_refill(flush_refill), .eret(eret), .epc(epc),
        .fetch_pc(o2_pc), .req_valid(o2_req), .fetch_mask(o2_mask),
        .ps_to_fs_valid(o2_fsv), .ps_ex(o2_ex), .ps_excode(o2_code),
        .redirect_pending(o2_pend)
    );

    pre_if_multi_fetch #(.FETCH_WIDTH(4)) u_dut4 (
        .clk(clk), .reset(reset), .fs_allowin(fs_allowin), .icache_busy(icache_busy),
        .br_taken(br_taken), .br_stall(br_stall), .br_target(br_target),
        .flush(flush), .flush_refill(flush_refill), .eret(eret), .epc(epc),
        .fetch_pc(o4_pc), .req_valid(o4_req), .fetch_mask(o4_mask),
        .ps_to_fs_valid(o4_fsv), .ps_ex(o4_ex), .ps_excode(o4_code),
        .redirect_pending(o4_pend)
    );

    // Behavioural model: one entry per instance (index 0 -> width 2, 1 -> width 4)
    logic [31:0] m_pc   [2];
    logic [31:0] m_pend [2];
    bit          m_hold [2];
    bit          m_drop [2];
    int          MW     [2] = '{2, 4};

    typedef struct {
        bit          busy, allow, br, stall;
        logic [31:0] tgt;
        bit          fl, refill, er;
        logic [31:0] ep;
        logic [31:0] e_pc;
        bit          e_req;
        logic [1:0]  e_mask;
        bit          e_fsv, e_ex, e_pend;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k]   = RESET_PC;
            m_pend[k] = 32'h0;
            m_hold[k] = 1'b0;
            m_drop[k] = 1'b0;
        end
    endtask

    task automatic model_update();
        logic [31:0] gb;
        logic [31:0] xt;
        bit          exc, brr, adv;
        exc = eret || flush;
        brr = br_taken && !br_stall;
        xt  = eret ? epc : (flush_refill ? REFILL_EX_PC : GENERAL_EX_PC);
        for (int k = 0; k < 2; k++) begin
            gb  = 32'(MW[k] * 4);
            adv = !icache_busy && fs_allowin && !m_drop[k];
            if (exc) begin
                m_pc[k]   = xt;
                m_hold[k] = 1'b0;
            end else if (m_hold[k]) begin
                if (brr) m_pend[k] = br_target;
                if (!icache_busy) begin
                    m_pc[k]   = m_pend[k];
                    m_hold[k] = 1'b0;
                end
            end else if (brr) begin
                if (adv) m_pc[k] = br_target;
                else begin
                    m_pend[k] = br_target;
                    m_hold[k] = 1'b1;
                end
            end else if (adv) begin
                m_pc[k] = m_pc[k] - (m_pc[k] % gb) + gb;
            end
            if (exc) m_drop[k] = icache_busy;
            else if (!icache_busy) m_drop[k] = 1'b0;
        end
    endtask

    task automatic check_model();
        logic [31:0] pc, mask, a_pc, a_mask;
        int          w, slot;
        bit          ex, req, fsv, a_req, a_fsv, a_ex, a_pend;
        logic [4:0]  a_code;
        for (int k = 0; k < 2; k++) begin
            pc   = m_pc[k];
            w    = MW[k];
            ex   = (pc % 4) != 0;
            slot = int'((pc % 32'(w * 4)) / 4);
            mask = ex ? 32'h0 : (((32'd1 << w) - 32'd1) & ~((32'd1 << slot) - 32'd1));
            req  = !icache_busy && !ex && !m_drop[k] && !m_hold[k];
            fsv  = !icache_busy && fs_allowin && !m_drop[k] && !m_hold[k];
            a_pc   = (k == 0) ? o2_pc   : o4_pc;
            a_mask = (k == 0) ? 32'(o2_mask) : 32'(o4_mask);
            a_req  = (k == 0) ? o2_req  : o4_req;
            a_fsv  = (k == 0) ? o2_fsv  : o4_fsv;
            a_ex   = (k == 0) ? o2_ex   : o4_ex;
            a_code = (k == 0) ? o2_code : o4_code;
            a_pend = (k == 0) ? o2_pend : o4_pend;
            check($sformatf("model_pc_w%0d", w),   a_pc, pc);
            check($sformatf("model_mask_w%0d", w), a_mask, mask);
            check($sformatf("model_req_w%0d", w),  32'(a_req), 32'(req));
            check($sformatf("model_fsv_w%0d", w),  32'(a_fsv), 32'(fsv));
            check($sformatf("model_ex_w%0d", w),   32'(a_ex), 32'(ex));
            check($sformatf("model_code_w%0d", w), 32'(a_code), ex ? 32'h4 : 32'h0);
            check($sformatf("model_pend_w%0d", w), 32'(a_pend), 32'(m_hold[k]));
        end
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic step();
        @(negedge clk);
        check_model();
        finish_cycle();
    endtask

    task automatic idle_inputs();
        icache_busy = 0; fs_allowin = 1; br_taken = 0; br_stall = 0; br_target = 32'h0;
        flush = 0; flush_refill = 0; eret = 0; epc = 32'h0;
    endtask

    task automatic add(input bit busy, allow, br, stall, input logic [31:0] tgt,
                       input bit fl, refill, er, input logic [31:0] ep,
                       input logic [31:0] e_pc, input bit e_req, input logic [1:0] e_mask,
                       input bit e_fsv, e_ex, e_pend);
        vec_t v;
        v.busy = busy; v.allow = allow; v.br = br; v.stall = stall; v.tgt = tgt;
        v.fl = fl; v.refill = refill; v.er = er; v.ep = ep;
        v.e_pc = e_pc; v.e_req = e_req; v.e_mask = e_mask;
        v.e_fsv = e_fsv; v.e_ex = e_ex; v.e_pend = e_pend;
        tbl.push_back(v);
    endtask

    initial begin
        logic [31:0] r;
        // busy allow br stall tgt | fl refill er epc | pc req mask fsv ex pend
        add(0,1,0,0,32'h0,        0,0,0,32'h0,        32'hBFC00000,1,2'b11,1,0,0);
        add(0,1,0,0,32'h0,        0,0,0,32'h0,        32'hBFC00008,1,2'b11,1,0,0);
        add(0,1,1,0,32'h80001004, 0,0,0,32'h0,        32'hBFC00010,1,2'b11,1,0,0);
        add(0,1,0,0,32'h0,        0,0,0,32'h0,        32'h80001004,1,2'b10,1,0,0);
        add(1,1,1,0,32'h80002000, 0,0,0,32'h0,        32'h80001008,0,2'b11,0,0,0);
        add(1,1,0,0,32'h0,        0,0,0,32'h0,        32'h80001008,0,2'b11,0,0,1);
        add(1,1,0,0,32'h0,        0,0,0,32'h0,        32'h80001008,0,2'b11,0,0,1);
        add(0,1,0,0,32'h0,        0,0,0,32'h0,        32'h80001008,0,2'b11,0,0,1);
        add(0,1,0,0,32'h0,        0,0,0,32'h0,        32'h80002000,1,2'b11,1,0,0);
        add(1,1,0,0,32'h0,        1,1,0,32'h0,        32'h80002008,0,2'b11,0,0,0);
        add(0,1,0,0,32'h0,        0,0,0,32'h0,        32'hBFC00200,0,2'b11,0,0,0);
        add(0,1,0,0,32'h0,        0,0,0,32'h0,        32'hBFC00200,1,2'b11,1,0,0);
        add(0,1,1,0,32'h12340000, 1,0,1,32'h80000102, 32'hBFC00208,1,2'b11,1,0,0);
        add(0,1,0,0,32'h0,        0,0,0,32'h0,        32'h80000102,0,2'b00,1,1,0);
        add(0,1,0,0,32'h0,        0,0,0,32'h0,        32'h80000108,1,2'b11,1,0,0);
        add(0,1,1,1,32'h12345678, 0,0,0,32'h0,        32'h80000110,1,2'b11,1,0,0);
        add(0,0,0,0,32'h0,        0,0,0,32'h0,        32'h80000118,1,2'b11,0,0,0);
        add(0,1,0,0,32'h0,        0,0,0,32'h0,        32'h80000118,1,2'b11,1,0,0);

        // Reset state
        idle_inputs();
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_pc_w2", o2_pc, RESET_PC);
        check("reset_pc_w4", o4_pc, RESET_PC);
        check("reset_req", 32'(o2_req), 32'h1);
        check("reset_pend", 32'(o2_pend), 32'h0);
        check("reset_mask_w4", 32'(o4_mask), 32'hF);
        @(posedge clk);
        #1 reset = 1'b0;

        // Directed table
        for (int i = 0; i < tbl.size(); i++) begin
            icache_busy = tbl[i].busy; fs_allowin = tbl[i].allow;
            br_taken = tbl[i].br; br_stall = tbl[i].stall; br_target = tbl[i].tgt;
            flush = tbl[i].fl; flush_refill = tbl[i].refill; eret = tbl[i].er; epc = tbl[i].ep;
            @(negedge clk);
            check($sformatf("tbl%0d_pc", i),   o2_pc, tbl[i].e_pc);
            check($sformatf("tbl%0d_req", i),  32'(o2_req), 32'(tbl[i].e_req));
            check($sformatf("tbl%0d_mask", i), 32'(o2_mask), 32'(tbl[i].e_mask));
            check($sformatf("tbl%0d_fsv", i),  32'(o2_fsv), 32'(tbl[i].e_fsv));
            check($sformatf("tbl%0d_ex", i),   32'(o2_ex), 32'(tbl[i].e_ex));
            check($sformatf("tbl%0d_code", i), 32'(o2_code), tbl[i].e_ex ? 32'h4 : 32'h0);
            check($sformatf("tbl%0d_pend", i), 32'(o2_pend), 32'(tbl[i].e_pend));
            check_model();
            finish_cycle();
        end

        // Wrap at the top of the address space
        idle_inputs();
        br_taken = 1; br_target = 32'hFFFFFFF0;
        step();
        idle_inputs();
        @(negedge clk);
        check("wrap_pc0_w4", o4_pc, 32'hFFFFFFF0);
        check("wrap_mask0_w4", 32'(o4_mask), 32'hF);
        check("wrap_pc0_w2", o2_pc, 32'hFFFFFFF0);
        check_model();
        finish_cycle();
        @(negedge clk);
        check("wrap_pc1_w4", o4_pc, 32'h00000000);
        check("wrap_mask1_w4", 32'(o4_mask), 32'hF);
        check("wrap_pc1_w2", o2_pc, 32'hFFFFFFF8);
        check_model();
        finish_cycle();

        // Asynchronous reset while a branch redirect is held
        icache_busy = 1; br_taken = 1; br_target = 32'h80004000;
        step();
        br_taken = 0;
        step();
        check("hold_before_reset", 32'(o2_pend), 32'h1);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("midhold_reset_pend", 32'(o2_pend), 32'h0);
        check("midhold_reset_pc_w2", o2_pc, RESET_PC);
        check("midhold_reset_pc_w4", o4_pc, RESET_PC);
        idle_inputs();
        @(posedge clk);
        #1 reset = 1'b0;
        step();

        // Randomized run against the model
        for (int n = 0; n < 3000; n++) begin
            icache_busy  = ($urandom_range(0, 9) < 3);
            fs_allowin   = ($urandom_range(0, 9) < 8);
            br_taken     = ($urandom_range(0, 99) < 15);
            br_stall     = ($urandom_range(0, 9) < 2);
            flush        = ($urandom_range(0, 99) < 3);
            flush_refill = $urandom_range(0, 1) == 1;
            eret         = ($urandom_range(0, 99) < 3);
            r            = $urandom();
            br_target    = ($urandom_range(0, 7) == 0) ? r : (r & 32'hFFFFFFFC);
            r            = $urandom();
            epc          = ($urandom_range(0, 3) == 0) ? r : (r & 32'hFFFFFFFC);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pre_if_multi_fetch.md
Name: pre_if_multi_fetch

Overview:
- Next-generation PC-generation (pre-IF) stage that fetches an aligned group of FETCH_WIDTH instructions per cycle instead of one.
- Holds the fetch PC and resolves redirects in priority order (eret, exception flush, branch, sequential).
- Issues the ICache request with a per-slot valid mask and registers redirects that arrive while the ICache is busy.
- Sits between the ID-stage branch bus / CP0 flush logic and the IF stage.

Parameters:
- FETCH_WIDTH, 2, instructions per fetch group; power of two, 1..4. LW = log2(FETCH_WIDTH).
- RESET_PC, 32'hBFC00000, PC loaded at reset.
- GENERAL_EX_PC, 32'hBFC00380, general exception vector.
- REFILL_EX_PC, 32'hBFC00200, TLB refill vector.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- fs_allowin  in  1  IF stage can accept a group
- icache_busy  in  1  ICache cannot accept a request this cycle
- br_taken  in  1  branch redirect request
- br_stall  in  1  branch not yet resolved; br_taken ignored while high
- br_target  in  32  branch target
- flush  in  1  exception flush
- flush_refill  in  1  qualifies flush: 1 selects REFILL_EX_PC
- eret  in  1  eret redirect
- epc  in  32  eret target
- fetch_pc  out  32  PC of the current group (registered)
- req_valid  out  1  ICache request valid
- fetch_mask  out  FETCH_WIDTH  per-slot valid bits
- ps_to_fs_valid  out  1  group handed to IF this cycle
- ps_ex  out  1  address-error exception on fetch_pc
- ps_excode  out  5  5'h04 (AdEL) when ps_ex=1, else 5'h00
- redirect_pending  out  1  a redirect is latched and waiting

Behaviour:
- Reset (async) values: fetch_pc=RESET_PC, state=RUN, pending_pc=0, redirect_pending=0, drop=0. Outputs derive from these values; with RESET_PC aligned, req_valid=1 when ~icache_busy.
- adv = ~icache_busy & fs_allowin.
- seq_pc = {fetch_pc[31:LW+2]+1, (LW+2)'b0}: start of the next aligned group. Wraps modulo 2^32.
- fetch_mask[i] = 1 iff i >= fetch_pc[LW+1:2] and fetch_pc[1:0]==0. A mid-group branch target masks the leading slots.
- ps_ex = (fetch_pc[1:0]!=0). When ps_ex=1: fetch_mask=0, req_valid=0, ps_to_fs_valid still follows adv so the exception reaches IF.
- req_valid = ~icache_busy & ~ps_ex & ~drop. ps_to_fs_valid = adv & ~drop.
- Redirect selection (combinational, priority order):
  - eret -> epc
  - flush -> (flush_refill ? REFILL_EX_PC : GENERAL_EX_PC)
  - br_taken & ~br_stall -> br_target
  - otherwise no redirect
- State RUN:
  - eret or flush: fetch_pc <= target the same cycle, regardless of busy. If icache_busy, set drop=1. Any pending redirect is cleared.
  - Branch redirect with adv: fetch_pc <= br_target.
  - Branch redirect with ~adv: pending_pc <= br_target, go to HOLD.
  - No redirect with adv: fetch_pc <= seq_pc.
  - Otherwise fetch_pc holds.
- State HOLD (redirect_pending=1):
  - ps_to_fs_valid=0 and req_valid=0.
  - When ~icache_busy: fetch_pc <= pending_pc, return to RUN.
  - eret/flush in HOLD overrides: fetch_pc <= new target, pending discarded, go to RUN.
  - A second branch in HOLD overwrites pending_pc.
- drop: cleared on the first cycle with ~icache_busy. During that cycle ps_to_fs_valid=0 and req_valid=0, so the stale in-flight response is squashed. The refetch occurs on the next cycle.
- Simultaneous eret and flush: eret wins.
- Flush with br_taken: the branch is ignored.
- Reset asserted mid-HOLD: returns to the reset values immediately.

Test Plan:
- FETCH_WIDTH=2; release reset with icache_busy=0, fs_allowin=1 -> fetch_pc sequence BFC00000, BFC00008, BFC00010; fetch_mask=2'b11 each cycle.
- br_taken=1, br_target=32'h80001004 with adv=1 -> next fetch_pc=80001004, fetch_mask=2'b10; following fetch_pc=80001008.
- br_taken while icache_busy=1 for 3 cycles -> redirect_pending=1 and ps_to_fs_valid=0 throughout; fetch_pc=target on the cycle after busy drops.
- flush=1, flush_refill=1, icache_busy=1 -> fetch_pc=BFC00200 next cycle, drop=1; first not-busy cycle has req_valid=0; the cycle after has req_valid=1.
- eret=1 with flush=1 and br_taken=1, epc=32'h80000102 -> fetch_pc=80000102, ps_ex=1, ps_excode=5'h04, fetch_mask=0, req_valid=0.
- FETCH_WIDTH=4, fetch_pc=FFFFFFF0, adv=1 -> next fetch_pc=00000000 (wrap), fetch_mask=4'b1111.
